// File: rtl/game_types.sv
// Shared game-phase encoding and overlay colours for the board renderer.
package game_types;

    typedef enum logic [1:0] {
        IDLE_PHASE      = 2'd0,
        PLACEMENT_PHASE = 2'd1,
        ATTACK_PHASE    = 2'd2,
        GAME_OVER_PHASE = 2'd3
    } game_state_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color_t;

    localparam color_t COLOR_CURSOR  = '{r: 4'hF, g: 4'hF, b: 4'h0};
    localparam color_t COLOR_INVALID = '{r: 4'hF, g: 4'h0, b: 4'h0};
    localparam color_t COLOR_BLACK   = '{r: 4'h0, g: 4'h0, b: 4'h0};

endpackage

// File: rtl/cursor_hit.sv
// Rectangle test for one cursor channel: ship footprint while placing,
// a single offset cell on the attack grid otherwise.
module cursor_hit #(
    parameter int CELL_SIZE = 32,
    parameter int GRID_DIM  = 10,
    parameter int COORD_W   = 10
) (
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    input  logic [COORD_W-1:0] offset_x,
    input  logic [3:0]         cell_x,
    input  logic [3:0]         cell_y,
    input  logic [3:0]         len,
    input  logic               orientation,
    input  logic               placement,
    output logic               hit,
    output logic               invalid
);
    localparam int W = COORD_W + 4;
    localparam logic [W-1:0] CELL = W'(CELL_SIZE);
    localparam logic [W-1:0] GRID = W'(GRID_DIM);

    logic [W-1:0] x0, y0, w, h, span, row_w, col_w;

    always_comb begin
        span = W'(len) * CELL;
        x0   = W'(cell_x) * CELL;
        y0   = W'(cell_y) * CELL;
        w    = CELL;
        h    = CELL;
        if (placement) begin
            if (orientation) h = span;
            else             w = span;
        end else begin
            x0 = x0 + W'(offset_x);
        end
    end

    assign row_w = W'(row);
    assign col_w = W'(col);

    // Half-open bounds; a zero-length ship gives an empty span and never hits.
    assign hit = (row_w >= y0) && (row_w < y0 + h) &&
                 (col_w >= x0) && (col_w < x0 + w);

    assign invalid = placement &&
                     (((orientation ? W'(cell_y) : W'(cell_x)) + W'(len)) > GRID);

endmodule

// File: rtl/cursor_overlay.sv
// Multi-channel cursor overlay with two-stage pixel pipeline.
// Optional blinking is enabled by defining CURSOR_BLINK_EN.
module cursor_overlay
    import game_types::*;
#(
    parameter int NUM_CURSORS  = 2,
    parameter int CELL_SIZE    = 32,
    parameter int GRID_DIM     = 10,
    parameter int COORD_W      = 10,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_start,
    input  logic [COORD_W-1:0]       row,
    input  logic [COORD_W-1:0]       col,
    input  logic [NUM_CURSORS-1:0]   cursor_en,
    input  logic [NUM_CURSORS*4-1:0] cursor_x,
    input  logic [NUM_CURSORS*4-1:0] cursor_y,
    input  logic [3:0]               ship_length,
    input  logic                     orientation,
    input  game_state_t              game_state,
    input  logic [COORD_W-1:0]       grid_offset_x,
    output logic [3:0]               vga_r,
    output logic [3:0]               vga_g,
    output logic [3:0]               vga_b,
    output logic                     overlay_hit
);
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("BLINK_FRAMES must be at least 1");
    end

    logic [NUM_CURSORS*4-1:0] sh_x, sh_y;
    logic [NUM_CURSORS-1:0]   sh_en;
    logic [3:0]               sh_len;
    logic                     sh_orient;
    logic [COORD_W-1:0]       sh_off;
    logic                     blink_visible;

    // Cursor geometry only moves on frame boundaries so a frame never tears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_x      <= '0;
            sh_y      <= '0;
            sh_en     <= '0;
            sh_len    <= '0;
            sh_orient <= 1'b0;
            sh_off    <= '0;
        end else if (frame_start) begin
            sh_x      <= cursor_x;
            sh_y      <= cursor_y;
            sh_en     <= cursor_en;
            sh_len    <= ship_length;
            sh_orient <= orientation;
            sh_off    <= grid_offset_x;
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] frame_cnt;
    game_state_t      prev_state;

    // A phase change restarts the blink visible, even on a frame_start cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt     <= '0;
            blink_visible <= 1'b1;
            prev_state    <= IDLE_PHASE;
        end else begin
            prev_state <= game_state;
            if (game_state != prev_state) begin
                frame_cnt     <= '0;
                blink_visible <= 1'b1;
            end else if (frame_start) begin
                if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt     <= '0;
                    blink_visible <= ~blink_visible;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign blink_visible = 1'b1;
`endif

    logic                   placement;
    logic [NUM_CURSORS-1:0] hit_raw, inv_raw, hit_vec;
    logic                   inv_sel;

    assign placement = (game_state == PLACEMENT_PHASE);

    for (genvar c = 0; c < NUM_CURSORS; c++) begin : g_ch
        cursor_hit #(
            .CELL_SIZE (CELL_SIZE),
            .GRID_DIM  (GRID_DIM),
            .COORD_W   (COORD_W)
        ) u_hit (
            .row         (row),
            .col         (col),
            .offset_x    (sh_off),
            .cell_x      (sh_x[c*4 +: 4]),
            .cell_y      (sh_y[c*4 +: 4]),
            .len         (sh_len),
            .orientation (sh_orient),
            .placement   (placement),
            .hit         (hit_raw[c]),
            .invalid     (inv_raw[c])
        );
    end

    assign hit_vec = hit_raw & sh_en & {NUM_CURSORS{blink_visible}};

    // Walk downward so the lowest-index hitting channel supplies the flag.
    always_comb begin
        inv_sel = 1'b0;
        for (int c = NUM_CURSORS - 1; c >= 0; c--) begin
            if (hit_vec[c]) inv_sel = inv_raw[c];
        end
    end

    // Stage 1: per-channel hits and winner's invalid flag
    logic [NUM_CURSORS-1:0] hit_vec_p1;
    logic                   invalid_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_vec_p1 <= '0;
            invalid_p1 <= 1'b0;
        end else begin
            hit_vec_p1 <= hit_vec;
            invalid_p1 <= inv_sel;
        end
    end

    // Stage 2: colour
    color_t color_p2;
    logic   hit_p2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            color_p2 <= COLOR_BLACK;
            hit_p2   <= 1'b0;
        end else if (|hit_vec_p1) begin
            color_p2 <= invalid_p1 ? COLOR_INVALID : COLOR_CURSOR;
            hit_p2   <= 1'b1;
        end else begin
            color_p2 <= COLOR_BLACK;
            hit_p2   <= 1'b0;
        end
    end

    assign vga_r       = color_p2.r;
    assign vga_g       = color_p2.g;
    assign vga_b       = color_p2.b;
    assign overlay_hit = hit_p2;

endmodule

// File: tb/tb_cursor_overlay.sv
// Self-checking bench for cursor_overlay: directed pixels plus random traffic
// compared every cycle against a behavioural model.
module tb_cursor_overlay;
    import game_types::*;

    localparam int NC = 2;
    localparam int CW = 10;
    localparam int BF = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_start = 1'b0;
    logic [CW-1:0]     row = '0, col = '0, grid_offset_x = '0;
    logic [NC-1:0]     cursor_en = '0;
    logic [NC*4-1:0]   cursor_x = '0, cursor_y = '0;
    logic [3:0]        ship_length = '0;
    logic              orientation = 1'b0;
    game_state_t       game_state = IDLE_PHASE;
    logic [3:0]        vga_r, vga_g, vga_b;
    logic              overlay_hit;

    int tests = 0;
    int fails = 0;

    cursor_overlay #(
        .NUM_CURSORS  (NC),
        .CELL_SIZE    (32),
        .GRID_DIM     (10),
        .COORD_W      (CW),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .row           (row),
        .col           (col),
        .cursor_en     (cursor_en),
        .cursor_x      (cursor_x),
        .cursor_y      (cursor_y),
        .ship_length   (ship_length),
        .orientation   (orientation),
        .game_state    (game_state),
        .grid_offset_x (grid_offset_x),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .overlay_hit   (overlay_hit)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int          m_x[NC];
    int          m_y[NC];
    logic [NC-1:0] m_en = '0;
    int          m_len = 0;
    logic        m_or = 1'b0;
    int          m_off = 0;
    logic        m_vis = 1'b1;
`ifdef CURSOR_BLINK_EN
    int          m_cnt = 0;
    game_state_t m_prev = IDLE_PHASE;
`endif
    logic [12:0] exp1 = '0, exp2 = '0;

    function automatic logic [12:0] model_px(input int r, input int c, input game_state_t gs);
        int x0, y0, w, h, win;
        logic place, inval;
        place = (gs == PLACEMENT_PHASE);
        win = -1;
        for (int k = 0; k < NC; k++) begin
            if (win < 0 && m_en[k] && m_vis) begin
                y0 = m_y[k] * 32;
                if (place) begin
                    x0 = m_x[k] * 32;
                    w  = m_or ? 32 : m_len * 32;
                    h  = m_or ? m_len * 32 : 32;
                end else begin
                    x0 = m_x[k] * 32 + m_off;
                    w  = 32;
                    h  = 32;
                end
                if (r >= y0 && r < y0 + h && c >= x0 && c < x0 + w) win = k;
            end
        end
        if (win < 0) return '0;
        inval = place && (((m_or ? m_y[win] : m_x[win]) + m_len) > 10);
        return inval ? {12'hF00, 1'b1} : {12'hFF0, 1'b1};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NC; k++) begin
                m_x[k] = 0;
                m_y[k] = 0;
            end
            m_en  = '0;
            m_len = 0;
            m_or  = 1'b0;
            m_off = 0;
            m_vis = 1'b1;
`ifdef CURSOR_BLINK_EN
            m_cnt  = 0;
            m_prev = IDLE_PHASE;
`endif
            exp1 = '0;
            exp2 = '0;
        end else begin
            exp2 = exp1;
            exp1 = model_px(int'(row), int'(col), game_state);
`ifdef CURSOR_BLINK_EN
            if (game_state != m_prev) begin
                m_cnt = 0;
                m_vis = 1'b1;
            end else if (frame_start) begin
                if (m_cnt == BF - 1) begin
                    m_cnt = 0;
                    m_vis = !m_vis;
                end else begin
                    m_cnt++;
                end
            end
            m_prev = game_state;
`endif
            if (frame_start) begin
                for (int k = 0; k < NC; k++) begin
                    m_x[k] = int'(cursor_x[k*4 +: 4]);
                    m_y[k] = int'(cursor_y[k*4 +: 4]);
                end
                m_en  = cursor_en;
                m_len = int'(ship_length);
                m_or  = orientation;
                m_off = int'(grid_offset_x);
            end
        end
    end

    always @(negedge clk) begin
        tests++;
        if ({vga_r, vga_g, vga_b, overlay_hit} !== exp2) begin
            fails++;
            $display("FAIL model_cmp t=%0t got rgb=%h hit=%b want rgb=%h hit=%b",
                     $time, {vga_r, vga_g, vga_b}, overlay_hit, exp2[12:1], exp2[0]);
        end
    end

    task automatic check_px(input int r, input int c, input logic [11:0] rgb,
                            input logic h, input string name);
        @(negedge clk);
        row = CW'(r);
        col = CW'(c);
        @(posedge clk);
        @(posedge clk);
        #1;
        tests++;
        if ({vga_r, vga_g, vga_b} !== rgb || overlay_hit !== h) begin
            fails++;
            $display("FAIL %s got rgb=%h hit=%b want rgb=%h hit=%b",
                     name, {vga_r, vga_g, vga_b}, overlay_hit, rgb, h);
        end
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic randomize_inputs();
        int offs[4] = '{0, 32, 96, 160};
        row = CW'($urandom_range(0, 191));
        col = CW'($urandom_range(0, 383));
        for (int k = 0; k < NC; k++) begin
            cursor_x[k*4 +: 4] = 4'($urandom_range(0, 5));
            cursor_y[k*4 +: 4] = 4'($urandom_range(0, 5));
        end
        cursor_en     = NC'($urandom_range(0, 3));
        ship_length   = 4'($urandom_range(0, 7));
        orientation   = 1'($urandom_range(0, 1));
        grid_offset_x = CW'(offs[$urandom_range(0, 3)]);
    endtask

    initial begin
        #1 reset = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            randomize_inputs();
            frame_start = 1'($urandom_range(0, 1));
            game_state  = game_state_t'($urandom_range(0, 3));
        end
        check_px(0, 0, 12'h000, 1'b0, "in_reset");

        // Release mid-frame: black until the first frame_start
        @(negedge clk);
        frame_start   = 1'b0;
        game_state    = PLACEMENT_PHASE;
        cursor_en     = 2'b01;
        cursor_x      = '0;
        cursor_y      = '0;
        ship_length   = 4'd1;
        orientation   = 1'b0;
        grid_offset_x = '0;
        reset = 1'b1;
        check_px(0, 0, 12'h000, 1'b0, "post_reset_black");
        pulse_frame();
        check_px(0, 0, 12'hFF0, 1'b1, "after_first_frame");

        // Placement, horizontal ship at (2,3) length 4
        cursor_x[3:0] = 4'd2;
        cursor_y[3:0] = 4'd3;
        ship_length   = 4'd4;
        pulse_frame();
        check_px(96, 64, 12'hFF0, 1'b1, "place_h_start");
        check_px(96, 191, 12'hFF0, 1'b1, "place_h_last_col");
        check_px(96, 192, 12'h000, 1'b0, "place_h_end_excl");
        check_px(128, 64, 12'h000, 1'b0, "place_h_row_excl");

        // Off-grid ship shows red
        cursor_x[3:0] = 4'd8;
        cursor_y[3:0] = 4'd0;
        pulse_frame();
        check_px(0, 256, 12'hF00, 1'b1, "place_invalid");

        // Vertical ship at (2,7) length 4 runs off the bottom
        cursor_x[3:0] = 4'd2;
        cursor_y[3:0] = 4'd7;
        orientation   = 1'b1;
        pulse_frame();
        check_px(351, 64, 12'hF00, 1'b1, "place_v_invalid");
        check_px(352, 64, 12'h000, 1'b0, "place_v_end_excl");

        // Zero-length ship never hits
        ship_length = 4'd0;
        pulse_frame();
        check_px(224, 64, 12'h000, 1'b0, "place_len0");

        // Overlap: ch0 valid at x=5, ch1 invalid at x=7, both length 4
        orientation = 1'b0;
        ship_length = 4'd4;
        cursor_en   = 2'b11;
        cursor_x    = {4'd7, 4'd5};
        cursor_y    = {4'd0, 4'd0};
        pulse_frame();
        check_px(0, 230, 12'hFF0, 1'b1, "priority_ch0");
        cursor_en = 2'b10;
        pulse_frame();
        check_px(0, 230, 12'hF00, 1'b1, "ch0_disabled");

        // Attack phase: single cell shifted by grid offset
        game_state    = ATTACK_PHASE;
        cursor_en     = 2'b01;
        cursor_x      = '0;
        cursor_y      = '0;
        grid_offset_x = CW'(320);
        pulse_frame();
        check_px(0, 320, 12'hFF0, 1'b1, "attack_hit");
        check_px(0, 0, 12'h000, 1'b0, "attack_unshifted");
        check_px(0, 352, 12'h000, 1'b0, "attack_end_excl");
        check_px(31, 351, 12'hFF0, 1'b1, "attack_corner");

        // Mid-frame move is deferred to the next frame
        cursor_x[3:0] = 4'd1;
        check_px(0, 320, 12'hFF0, 1'b1, "move_old_pos");
        check_px(0, 352, 12'h000, 1'b0, "move_new_not_yet");
        pulse_frame();
        check_px(0, 352, 12'hFF0, 1'b1, "move_new_pos");
        check_px(0, 320, 12'h000, 1'b0, "move_old_gone");

`ifdef CURSOR_BLINK_EN
        game_state = IDLE_PHASE;
        @(posedge clk);
        check_px(0, 352, 12'hFF0, 1'b1, "blink_restart");
        pulse_frame();
        check_px(0, 352, 12'hFF0, 1'b1, "blink_vis_f1");
        pulse_frame();
        check_px(0, 352, 12'h000, 1'b0, "blink_hid_f2");
        pulse_frame();
        check_px(0, 352, 12'h000, 1'b0, "blink_hid_f3");
        pulse_frame();
        check_px(0, 352, 12'hFF0, 1'b1, "blink_vis_f4");
        pulse_frame();
        pulse_frame();
        check_px(0, 352, 12'h000, 1'b0, "blink_hid_f6");
        game_state = ATTACK_PHASE;
        @(posedge clk);
        check_px(0, 352, 12'hFF0, 1'b1, "blink_state_change");
`endif

        // Random traffic against the model
        game_state = PLACEMENT_PHASE;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            randomize_inputs();
            frame_start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0)
                game_state = game_state_t'($urandom_range(0, 3));
            reset = (i >= 2000 && i < 2003) ? 1'b0 : 1'b1;
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
